// File: rtl/dis_pkg.sv
// Shared constants and types for the dispatch controller.
//   RS_NUM   : number of reservation stations
//   RS_DEPTH : entries per station (credit counter reset/reload value)
//   CNT_W    : credit counter width, holds 0..RS_DEPTH
package dis_pkg;

    localparam int RS_NUM   = 4;
    localparam int RS_DEPTH = 8;
    localparam int CNT_W    = 4;

    // RUN   : both slots of the RR/DIS register still pending
    // HOLD2 : slot 1 already dispatched, slot 2 still pending
    typedef enum logic {
        RUN   = 1'b0,
        HOLD2 = 1'b1
    } dis_state_t;

    typedef logic [1:0]       rs_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dis_ctrl_if.sv
// Dispatch bus between the RR/DIS register / reservation stations and dis_ctrl.
//   slave  : seen by dis_ctrl (instruction/issue inputs, dispatch outputs)
//   master : seen by the surrounding pipeline (or a testbench)
interface dis_ctrl_if;
    import dis_pkg::*;

    logic                    recover;
    logic                    valid1;
    logic                    valid2;
    logic                    res_en1;
    logic                    res_en2;
    rs_idx_t                 resnum1;
    rs_idx_t                 resnum2;
    logic [RS_NUM-1:0]       rs_issue;

    logic                    dis_we1;
    logic                    dis_we2;
    rs_idx_t                 dis_sel1;
    rs_idx_t                 dis_sel2;
    logic                    dis_fire1;
    logic                    dis_fire2;
    logic                    stall;
    logic [RS_NUM*CNT_W-1:0] free_cnt;
    logic                    cnt_err;

    modport master (
        output recover, valid1, valid2, res_en1, res_en2, resnum1, resnum2, rs_issue,
        input  dis_we1, dis_we2, dis_sel1, dis_sel2, dis_fire1, dis_fire2, stall,
               free_cnt, cnt_err
    );

    modport slave (
        input  recover, valid1, valid2, res_en1, res_en2, resnum1, resnum2, rs_issue,
        output dis_we1, dis_we2, dis_sel1, dis_sel2, dis_fire1, dis_fire2, stall,
               free_cnt, cnt_err
    );

endinterface

// File: rtl/rs_credit_cnt.sv
// Free-entry credit counter for one reservation station.
//   clk, rst   : clock, asynchronous active-low reset (count -> RS_DEPTH)
//   i_issue    : one entry freed by the station this cycle
//   i_alloc    : entries written by dispatch this cycle (0..2)
//   i_recover  : flush, reload to RS_DEPTH, issue ignored
//   o_cnt      : registered credit count
//   o_ovf      : issue arrived while already full (combinational pulse)
module rs_credit_cnt
    import dis_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_issue,
    input  logic [1:0] i_alloc,
    input  logic       i_recover,
    output cnt_t       o_cnt,
    output logic       o_ovf
);

    cnt_t r_cnt;
    logic w_full;
    cnt_t w_inc;

    assign w_full = (r_cnt == cnt_t'(RS_DEPTH));
    // The +1 saturates at full, but a same-cycle allocation still decrements.
    assign w_inc  = cnt_t'(i_issue && !w_full);
    assign o_ovf  = i_issue && w_full && !i_recover;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= cnt_t'(RS_DEPTH);
        end else if (i_recover) begin
            r_cnt <= cnt_t'(RS_DEPTH);
        end else begin
            r_cnt <= r_cnt + w_inc - cnt_t'(i_alloc);
        end
    end

endmodule

// File: rtl/dis_ctrl.sv
// Dispatch-stage controller for the dual-issue OoO core.
// Decides, strictly in program order, which of the two instructions in the
// RR/DIS register are written into their reservation station, based on
// per-station credit counters; stalls the front end when the pair cannot
// fully dispatch.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : dis_ctrl_if.slave (instructions, issue pulses, recover in;
//              write strobes, selects, fires, stall, counters, cnt_err out)
module dis_ctrl
    import dis_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dis_ctrl_if.slave    bus
);

    dis_state_t                  r_state;
    dis_state_t                  w_state_nxt;
    logic                        r_cnt_err;

    logic [RS_NUM-1:0][CNT_W-1:0] w_cnt;
    logic [RS_NUM-1:0]           w_ovf;
    logic [1:0]                  w_alloc [RS_NUM];

    logic                        w_need1;
    logic                        w_need2;
    cnt_t                        w_cnt1;
    cnt_t                        w_cnt2;
    logic                        w_ok1;
    logic                        w_ok2;
    cnt_t                        w_need2_cr;
    logic                        w_we1;
    logic                        w_we2;
    logic                        w_fire1;
    logic                        w_fire2;
    logic                        w_stall;

    assign w_need1 = bus.valid1 && bus.res_en1;
    assign w_need2 = bus.valid2 && bus.res_en2;
    assign w_cnt1  = w_cnt[bus.resnum1];
    assign w_cnt2  = w_cnt[bus.resnum2];
    assign w_ok1   = !w_need1 || (w_cnt1 != '0);

    // In RUN, slot 2 must also leave room for a slot-1 write to the same
    // station this cycle. In HOLD2 slot 1 is already gone, so one credit does.
    always_comb begin
        w_need2_cr = cnt_t'(1);
        if (r_state == RUN && w_need1 && w_ok1 && (bus.resnum1 == bus.resnum2))
            w_need2_cr = cnt_t'(2);
    end
    assign w_ok2 = !w_need2 || (w_cnt2 >= w_need2_cr);

    // Next-state and dispatch decisions
    always_comb begin
        w_state_nxt = r_state;
        w_we1       = 1'b0;
        w_we2       = 1'b0;
        w_fire1     = 1'b0;
        w_fire2     = 1'b0;
        w_stall     = 1'b0;
        if (bus.recover) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_ok1) begin
                        w_fire1 = bus.valid1;
                        w_we1   = w_need1;
                        if (w_ok2) begin
                            w_fire2 = bus.valid2;
                            w_we2   = w_need2;
                        end else begin
                            w_stall     = 1'b1;
                            w_state_nxt = HOLD2;
                        end
                    end else begin
                        // slot 2 never bypasses a blocked slot 1
                        w_stall = 1'b1;
                    end
                end
                HOLD2: begin
                    if (w_ok2) begin
                        w_fire2     = bus.valid2;
                        w_we2       = w_need2;
                        w_state_nxt = RUN;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    // Per-station credit counters
    for (genvar s = 0; s < RS_NUM; s++) begin : g_rs
        assign w_alloc[s] = {1'b0, w_we1 && (bus.resnum1 == rs_idx_t'(s))}
                          + {1'b0, w_we2 && (bus.resnum2 == rs_idx_t'(s))};

        rs_credit_cnt u_cnt (
            .clk       (clk),
            .rst       (rst),
            .i_issue   (bus.rs_issue[s]),
            .i_alloc   (w_alloc[s]),
            .i_recover (bus.recover),
            .o_cnt     (w_cnt[s]),
            .o_ovf     (w_ovf[s])
        );

        assign bus.free_cnt[s*CNT_W +: CNT_W] = w_cnt[s];
    end

    // Sticky overflow flag; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt_err <= 1'b0;
        else      r_cnt_err <= r_cnt_err || (|w_ovf);
    end

    assign bus.dis_we1   = w_we1;
    assign bus.dis_we2   = w_we2;
    assign bus.dis_sel1  = bus.resnum1;
    assign bus.dis_sel2  = bus.resnum2;
    assign bus.dis_fire1 = w_fire1;
    assign bus.dis_fire2 = w_fire2;
    assign bus.stall     = w_stall;
    assign bus.cnt_err   = r_cnt_err;

endmodule

// File: tb/tb_dis_ctrl.sv
// Self-checking bench for dis_ctrl: directed scenarios followed by random
// traffic, all compared against a slot-by-slot credit model.
module tb_dis_ctrl;
    import dis_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_tot  = 0;

    dis_ctrl_if bus ();

    dis_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int m_cnt [RS_NUM];
    bit m_hold;
    bit m_err;

    // last sampled combinational outputs for directed spot checks
    logic o_we1, o_we2, o_fire1, o_fire2, o_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int fc(input int s);
        return int'(bus.free_cnt[s*CNT_W +: CNT_W]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < RS_NUM; s++) m_cnt[s] = RS_DEPTH;
        m_hold = 0;
        m_err  = 0;
    endtask

    task automatic check_regs(input string tag);
        for (int s = 0; s < RS_NUM; s++)
            chk($sformatf("%s_cnt%0d", tag, s), 32'(fc(s)), 32'(m_cnt[s]));
        chk({tag, "_err"}, 32'(bus.cnt_err), 32'(m_err));
    endtask

    task automatic set_in(input bit v1, input bit e1, input int r1,
                          input bit v2, input bit e2, input int r2,
                          input logic [3:0] iss, input bit rec);
        bus.valid1   = v1;  bus.res_en1 = e1;  bus.resnum1 = rs_idx_t'(r1);
        bus.valid2   = v2;  bus.res_en2 = e2;  bus.resnum2 = rs_idx_t'(r2);
        bus.rs_issue = iss; bus.recover = rec;
    endtask

    // One cycle: inputs already driven just after a rising edge.
    task automatic step(input string tag);
        int tmp [RS_NUM];
        bit f1, f2, w1, w2, b1, b2, st;
        int r1, r2;
        #2;
        r1 = int'(bus.resnum1);
        r2 = int'(bus.resnum2);
        for (int s = 0; s < RS_NUM; s++) tmp[s] = m_cnt[s];
        f1 = 0; f2 = 0; w1 = 0; w2 = 0; b1 = 0; b2 = 0;
        if (!bus.recover) begin
            // take pending slots in order, consuming credits; stop at first blocked slot
            if (!m_hold) begin
                if (bus.valid1 && bus.res_en1) begin
                    if (tmp[r1] > 0) begin tmp[r1]--; w1 = 1; f1 = 1; end
                    else b1 = 1;
                end else f1 = bus.valid1;
            end
            if (!b1) begin
                if (bus.valid2 && bus.res_en2) begin
                    if (tmp[r2] > 0) begin tmp[r2]--; w2 = 1; f2 = 1; end
                    else b2 = 1;
                end else f2 = bus.valid2;
            end
        end
        st = b1 || b2;
        o_we1 = bus.dis_we1; o_we2 = bus.dis_we2;
        o_fire1 = bus.dis_fire1; o_fire2 = bus.dis_fire2; o_stall = bus.stall;
        chk({tag, "_we1"},   32'(bus.dis_we1),   32'(w1));
        chk({tag, "_we2"},   32'(bus.dis_we2),   32'(w2));
        chk({tag, "_fire1"}, 32'(bus.dis_fire1), 32'(f1));
        chk({tag, "_fire2"}, 32'(bus.dis_fire2), 32'(f2));
        chk({tag, "_stall"}, 32'(bus.stall),     32'(st));
        chk({tag, "_sel1"},  32'(bus.dis_sel1),  32'(r1));
        chk({tag, "_sel2"},  32'(bus.dis_sel2),  32'(r2));
        // counter/flag update
        if (bus.recover) begin
            for (int s = 0; s < RS_NUM; s++) m_cnt[s] = RS_DEPTH;
            m_hold = 0;
        end else begin
            for (int s = 0; s < RS_NUM; s++) begin
                if (bus.rs_issue[s]) begin
                    if (m_cnt[s] == RS_DEPTH) m_err = 1;
                    else m_cnt[s]++;
                end
                if (w1 && r1 == s) m_cnt[s]--;
                if (w2 && r2 == s) m_cnt[s]--;
            end
            m_hold = b2;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input string tag);
        set_in(0, 0, 0, 0, 0, 0, 4'h0, 0);
        rst = 1'b0;
        model_reset();
        #2;
        chk({tag, "_we1"},   32'(bus.dis_we1),   32'd0);
        chk({tag, "_fire2"}, 32'(bus.dis_fire2), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall),     32'd0);
        check_regs(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 4'h0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst0");
        chk("rst0_all8", 32'(bus.free_cnt), 32'h8888);

        // both target distinct stations after reset
        set_in(1, 1, 0, 1, 1, 1, 4'h0, 0);
        step("tp1");
        chk("tp1_we2_lit", 32'(o_we2), 32'd1);
        chk("tp1_c0", 32'(fc(0)), 32'd7);
        chk("tp1_c1", 32'(fc(1)), 32'd7);

        // drain station 2 to one credit, then send a same-station pair
        for (int i = 0; i < 7; i++) begin
            set_in(1, 1, 2, 0, 0, 0, 4'h0, 0);
            step("fill2");
        end
        chk("fill2_c2", 32'(fc(2)), 32'd1);
        set_in(1, 1, 2, 1, 1, 2, 4'h0, 0);
        step("tp2_c0");
        chk("tp2_c0_stall", 32'(o_stall), 32'd1);
        chk("tp2_c0_we2",   32'(o_we2),   32'd0);
        set_in(1, 1, 2, 1, 1, 2, 4'h4, 0);
        step("tp2_c1");
        chk("tp2_c1_stall", 32'(o_stall), 32'd1);
        set_in(1, 1, 2, 1, 1, 2, 4'h0, 0);
        step("tp2_c2");
        chk("tp2_c2_we2",   32'(o_we2),   32'd1);
        chk("tp2_c2_stall", 32'(o_stall), 32'd0);

        // in-order: blocked slot 1 holds back a dispatchable slot 2
        for (int i = 0; i < 8; i++) begin
            set_in(1, 1, 3, 0, 0, 0, 4'h0, 0);
            step("fill3");
        end
        set_in(1, 1, 3, 1, 1, 0, 4'h0, 0);
        step("tp3_a");
        chk("tp3_a_we2", 32'(o_we2), 32'd0);
        step("tp3_b");
        set_in(1, 1, 3, 1, 1, 0, 4'h8, 0);
        step("tp3_iss");
        set_in(1, 1, 3, 1, 1, 0, 4'h0, 0);
        step("tp3_go");
        chk("tp3_go_we1", 32'(o_we1), 32'd1);

        // no-RS slot 1 fires, slot 2 stuck on empty station 2
        set_in(1, 0, 1, 1, 1, 2, 4'h0, 0);
        step("tp4");
        chk("tp4_fire1", 32'(o_fire1), 32'd1);
        chk("tp4_stall", 32'(o_stall), 32'd1);
        // still holding: slot-1 fields are now irrelevant
        set_in(1, 1, 2, 1, 1, 2, 4'h0, 0);
        step("tp4_hold");

        // recover while in HOLD2
        set_in(1, 1, 2, 1, 1, 2, 4'h4, 1);
        step("tp5_rec");
        chk("tp5_stall", 32'(o_stall), 32'd0);
        chk("tp5_all8", 32'(bus.free_cnt), 32'h8888);

        // issue into a full station -> sticky error survives recover
        set_in(0, 0, 0, 0, 0, 0, 4'h1, 0);
        step("tp6_ovf");
        chk("tp6_err", 32'(bus.cnt_err), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 4'h0, 1);
        step("tp6_rec");
        chk("tp6_err_rec", 32'(bus.cnt_err), 32'd1);
        // full station: issue holds, allocation still decrements
        set_in(1, 1, 1, 0, 0, 0, 4'h2, 0);
        step("ovf_alloc");
        chk("ovf_alloc_c1", 32'(fc(1)), 32'd7);
        do_reset("rst1");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] iss;
            iss = '0;
            for (int s = 0; s < RS_NUM; s++) iss[s] = ($urandom_range(0, 3) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                   iss, $urandom_range(0, 49) == 0);
            step($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
